// File: rtl/soc_system_audio_input_fifo.sv
// Audio input sample FIFO with an Avalon-MM slave: DATA pop, STATUS, CONTROL, THRESHOLD, LIVE.
// Samples arrive on in_port/in_valid. The level interrupt and the overflow interrupt share irq.
module soc_system_audio_input_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [2:0]            address,
   input  logic                  chipselect,
   input  logic                  read,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   input  logic [DATA_WIDTH-1:0] in_port,
   input  logic                  in_valid,
   output logic [31:0]           readdata,
   output logic                  irq
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_STATUS = 3'd1;
   localparam logic [2:0] ADDR_CTRL   = 3'd2;
   localparam logic [2:0] ADDR_THRESH = 3'd3;
   localparam logic [2:0] ADDR_LIVE   = 3'd4;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW:0]           level;
   logic                  overflow;
   logic                  underflow;
   logic                  enable;
   logic                  irq_en;
   logic [8:0]            threshold;

   logic                  wr_en;
   logic                  rd_en;
   logic                  empty;
   logic                  full;
   logic                  pop;
   logic                  push_req;
   logic                  push;
   logic                  flush;
   logic                  of_set;
   logic                  uf_set;
   logic                  of_clr;
   logic                  uf_clr;
   logic [8:0]            level_9;
   logic [DATA_WIDTH-1:0] head;
   logic [31:0]           rdata_next;

   assign wr_en    = chipselect & ~write_n;
   assign rd_en    = chipselect & read;
   assign empty    = (level == '0);
   assign full     = (level == FULL_LEVEL);
   assign pop      = rd_en & (address == ADDR_DATA) & ~empty;
   assign uf_set   = rd_en & (address == ADDR_DATA) & empty;
   assign push_req = in_valid & enable;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
   assign push     = push_req & (~full | pop);
   assign of_set   = push_req & full & ~pop;
   assign flush    = wr_en & (address == ADDR_CTRL) & writedata[2];
   assign of_clr   = wr_en & (address == ADDR_STATUS) & writedata[18];
   assign uf_clr   = wr_en & (address == ADDR_STATUS) & writedata[19];
   assign level_9  = 9'(level);
   assign head     = empty ? '0 : mem[rd_ptr];

   logic unused_wdata;
   assign unused_wdata = ^{writedata[31:20], writedata[17:9]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      level <= level + 1'b1;
         else if (pop && !push) level <= level - 1'b1;
      end
   end

   // Storage is never visible while empty, so it has no reset.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= in_port;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
         enable    <= 1'b0;
         irq_en    <= 1'b0;
         threshold <= '0;
      end else begin
         overflow  <= of_set | (overflow & ~of_clr);
         underflow <= uf_set | (underflow & ~uf_clr);
         if (wr_en && address == ADDR_CTRL) begin
            enable <= writedata[0];
            irq_en <= writedata[1];
         end
         if (wr_en && address == ADDR_THRESH) threshold <= writedata[8:0];
      end
   end

   always_comb begin
      rdata_next = '0;
      unique case (address)
         ADDR_DATA:   rdata_next = 32'(head);
         ADDR_STATUS: rdata_next = {12'b0, underflow, overflow, full, empty, 7'b0, level_9};
         ADDR_CTRL:   rdata_next = {30'b0, irq_en, enable};
         ADDR_THRESH: rdata_next = {23'b0, threshold};
         ADDR_LIVE:   rdata_next = 32'(in_port);
         default:     rdata_next = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) readdata <= '0;
      else          readdata <= rdata_next;
   end

   assign irq = irq_en & (((threshold != '0) & (level_9 >= threshold)) | overflow);

endmodule

// File: tb/tb_soc_system_audio_input_fifo.sv
// Scoreboard bench for soc_system_audio_input_fifo: a queue-based reference model predicts
// every register read and the irq level; a monitor checks readdata one cycle after each read.
module tb_soc_system_audio_input_fifo;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        read;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] in_port;
   logic        in_valid;
   logic [31:0] readdata;
   logic        irq;

   soc_system_audio_input_fifo #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .read(read), .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .in_valid(in_valid), .readdata(readdata), .irq(irq)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // reference model
   logic [31:0] mq[$];
   bit          m_en, m_ien, m_of, m_uf;
   logic [8:0]  m_thr;

   // scoreboard
   logic [31:0] exp_q[$];
   string       name_q[$];

   function automatic logic [31:0] model_read(input logic [2:0] a, input logic [31:0] live);
      logic [31:0] s;
      s = '0;
      case (a)
         3'd0: s = (mq.size() != 0) ? mq[0] : 32'h0;
         3'd1: begin
            s[8:0] = 9'(mq.size());
            s[16]  = (mq.size() == 0);
            s[17]  = (mq.size() == DEPTH);
            s[18]  = m_of;
            s[19]  = m_uf;
         end
         3'd2: s = {30'b0, m_ien, m_en};
         3'd3: s = {23'b0, m_thr};
         3'd4: s = live;
         default: s = '0;
      endcase
      return s;
   endfunction

   function automatic bit model_irq();
      return m_ien && ((m_thr != 0 && mq.size() >= int'(m_thr)) || m_of);
   endfunction

   task automatic model_reset();
      mq.delete();
      m_en = 0; m_ien = 0; m_of = 0; m_uf = 0; m_thr = '0;
   endtask

   // One bus/sample cycle: drive at negedge, predict, update the model.
   task automatic cyc(input bit rd, input bit wr, input logic [2:0] a, input logic [31:0] wd,
                      input bit iv, input logic [31:0] smp, input string nm);
      bit pop_now, preq;
      @(negedge clk);
      checks++;
      if (irq !== model_irq()) begin
         errors++;
         $display("FAIL irq before %s: got %b want %b", nm, irq, model_irq());
      end
      in_port    = smp;
      in_valid   = iv;
      chipselect = rd | wr;
      read       = rd;
      write_n    = !wr;
      address    = a;
      writedata  = wd;
      if (rd) begin
         exp_q.push_back(model_read(a, smp));
         name_q.push_back(nm);
      end
      pop_now = rd && a == 3'd0 && mq.size() != 0;
      preq    = iv && m_en;
      if (wr) begin
         case (a)
            3'd1: begin
               if (wd[18]) m_of = 0;
               if (wd[19]) m_uf = 0;
            end
            3'd2: begin m_en = wd[0]; m_ien = wd[1]; end
            3'd3: m_thr = wd[8:0];
            default: ;
         endcase
      end
      if (rd && a == 3'd0 && mq.size() == 0) m_uf = 1;
      if (preq && mq.size() == DEPTH && !pop_now) m_of = 1;
      if (wr && a == 3'd2 && wd[2]) mq.delete();
      else begin
         if (pop_now) void'(mq.pop_front());
         if (preq && mq.size() < DEPTH) mq.push_back(smp);
      end
   endtask

   task automatic idle(input string nm);
      cyc(0, 0, 3'd0, 32'h0, 0, $urandom, nm);
   endtask

   // monitor: a read issued at edge N shows on readdata after edge N
   bit pend = 0;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) pend <= 1'b0;
      else          pend <= chipselect & read;
   end

   always @(negedge clk) begin
      logic [31:0] e;
      string n;
      if (pend) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: readdata %h arrived with no expected read", readdata);
         end else begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            if (readdata !== e) begin
               errors++;
               $display("FAIL %s: readdata got %h want %h", n, readdata, e);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      bit rd, wr, iv;
      logic [2:0] a;
      logic [31:0] wd;
      int r;

      reset_n = 1'b0; chipselect = 0; read = 0; write_n = 1; address = '0;
      writedata = '0; in_port = '0; in_valid = 0;
      model_reset();
      #23;
      checks++;
      if (readdata !== 32'h0) begin errors++; $display("FAIL reset readdata: got %h want 0", readdata); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL reset irq: got %b want 0", irq); end
      @(negedge clk);
      reset_n = 1'b1;

      cyc(1, 0, 3'd1, 0, 0, $urandom, "status after reset");
      cyc(1, 0, 3'd2, 0, 0, $urandom, "control after reset");

      // basic push / pop in order
      cyc(0, 1, 3'd2, 32'h1, 0, $urandom, "enable");
      cyc(0, 0, 3'd0, 0, 1, 32'h11, "push 11");
      cyc(0, 0, 3'd0, 0, 1, 32'h22, "push 22");
      cyc(0, 0, 3'd0, 0, 1, 32'h33, "push 33");
      cyc(1, 0, 3'd0, 0, 0, $urandom, "pop 11");
      cyc(1, 0, 3'd0, 0, 0, $urandom, "pop 22");
      cyc(1, 0, 3'd0, 0, 0, $urandom, "pop 33");
      cyc(1, 0, 3'd1, 0, 0, $urandom, "status empty");

      // underflow and its clear
      cyc(1, 0, 3'd0, 0, 0, $urandom, "data on empty");
      cyc(1, 0, 3'd1, 0, 0, $urandom, "status underflow");
      cyc(0, 1, 3'd1, 32'h80000, 0, $urandom, "clear underflow");
      cyc(1, 0, 3'd1, 0, 0, $urandom, "status uf cleared");

      // fill past full
      for (int i = 0; i < DEPTH + 1; i++) cyc(0, 0, 3'd0, 0, 1, $urandom, "fill");
      cyc(1, 0, 3'd1, 0, 0, $urandom, "status full overflow");
      cyc(0, 1, 3'd1, 32'h40000, 0, $urandom, "clear overflow");
      cyc(1, 0, 3'd1, 0, 0, $urandom, "status of cleared");
      cyc(1, 0, 3'd0, 0, 1, $urandom, "push+pop at full");
      cyc(1, 0, 3'd1, 0, 0, $urandom, "status after push+pop");
      cyc(0, 1, 3'd1, 32'h40000, 1, $urandom, "clear with overflow");
      cyc(1, 0, 3'd1, 0, 0, $urandom, "status set wins");
      cyc(0, 1, 3'd1, 32'h40000, 0, $urandom, "clear overflow again");
      cyc(1, 0, 3'd4, 0, 0, $urandom, "live");
      cyc(1, 0, 3'd6, 0, 0, $urandom, "unmapped");

      // flush with concurrent push
      cyc(0, 1, 3'd2, 32'h5, 1, $urandom, "flush");
      cyc(1, 0, 3'd1, 0, 0, $urandom, "status after flush");
      cyc(1, 0, 3'd2, 0, 0, $urandom, "control flush reads 0");

      // threshold interrupt
      cyc(0, 1, 3'd3, 32'h4, 0, $urandom, "threshold 4");
      cyc(0, 1, 3'd2, 32'h3, 0, $urandom, "irq_en");
      cyc(1, 0, 3'd3, 0, 0, $urandom, "threshold readback");
      for (int i = 0; i < 4; i++) cyc(0, 0, 3'd0, 0, 1, $urandom, "thr push");
      idle("irq at 4");
      cyc(1, 0, 3'd0, 0, 0, $urandom, "thr pop");
      idle("irq after pop");
      cyc(0, 0, 3'd0, 0, 1, $urandom, "push to 4");
      cyc(0, 0, 3'd0, 0, 1, $urandom, "push to 5");
      idle("pre reset");

      // asynchronous reset mid-operation
      @(negedge clk);
      checks++;
      if (irq !== model_irq()) begin errors++; $display("FAIL irq pre-reset: got %b want %b", irq, model_irq()); end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (readdata !== 32'h0) begin errors++; $display("FAIL async reset readdata: got %h want 0", readdata); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL async reset irq: got %b want 0", irq); end
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      cyc(1, 0, 3'd1, 0, 0, $urandom, "status after mid reset");
      cyc(0, 1, 3'd2, 32'h1, 0, $urandom, "re-enable");
      cyc(0, 0, 3'd0, 0, 1, 32'hAB, "push AB");
      cyc(1, 0, 3'd0, 0, 0, $urandom, "pop AB");

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         r  = $urandom_range(0, 9);
         iv = ($urandom_range(0, 2) != 0);
         rd = (r < 4);
         wr = (r == 4 || r == 5);
         a  = '0;
         wd = '0;
         if (rd) a = (r < 2) ? 3'd0 : 3'($urandom_range(0, 7));
         if (wr) begin
            a = 3'($urandom_range(1, 7));
            case (a)
               3'd1: wd = {12'b0, 1'($urandom), 1'($urandom), 18'b0};
               3'd2: wd = {29'b0, (!iv && $urandom_range(0, 7) == 0), 1'($urandom),
                           ($urandom_range(0, 5) != 0)};
               3'd3: wd = 32'($urandom_range(0, 20));
               default: wd = $urandom;
            endcase
         end
         cyc(rd, wr, a, wd, iv, $urandom, "random");
      end
      idle("drain");
      idle("drain");
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: %0d reads unanswered, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
